// File: rtl/pdp8_dbreak_chan.sv
// PDP-8 three-cycle data-break channel: WC/CA update plus one data word per break,
// with a device-side FIFO decoupling the disk backend from the memory port.
module pdp8_dbreak_chan #(
  parameter logic [11:0] WC_ADDR    = 12'o7750,
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_AW    = 4,
  parameter int          FLD_W      = 3,
  parameter int          INCR_CA    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                dir_to_mem,
  input  logic [FLD_W-1:0]    field,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                wc_ovf,
  output logic                ram_read_req,
  output logic                ram_write_req,
  input  logic                ram_done,
  output logic [FLD_W+11:0]   ram_ma,
  input  logic [11:0]         ram_in,
  output logic [11:0]         ram_out,
  input  logic [11:0]         dev_wdata,
  input  logic                dev_wvalid,
  output logic                dev_wready,
  output logic [11:0]         dev_rdata,
  output logic                dev_rvalid,
  input  logic                dev_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WC_RD, S_WC_WR, S_CA_RD, S_CA_WR, S_DAT, S_FIN
  } state_t;

  localparam logic [11:0]      CA_ADDR  = WC_ADDR + 12'd1;
  localparam logic [11:0]      CA_STEP  = (INCR_CA != 0) ? 12'd1 : 12'd0;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FLD_W-1:0] FLD0     = {FLD_W{1'b0}};

  state_t               state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic                 rd_q, rd_d, wr_q, wr_d;
  logic [FLD_W+11:0]    ma_q, ma_d;
  logic [11:0]          out_q, out_d;
  logic                 dir_q, dir_d, abort_q, abort_d, wcz_q, wcz_d;
  logic [FLD_W-1:0]     fld_q, fld_d;
  logic [FIFO_AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic [11:0]          fifo_mem [FIFO_DEPTH];

  logic                 mem_ack_s, chan_push_s, chan_pop_s, flush_s;
  logic                 fifo_full_s, fifo_empty_s, push_s, pop_s, abort_seen_s;
  logic [11:0]          push_data_s;

  assign fifo_full_s  = (cnt_q == FULL_CNT);
  assign fifo_empty_s = (cnt_q == {(FIFO_AW+1){1'b0}});
  assign mem_ack_s    = (rd_q | wr_q) & ram_done;
  assign abort_seen_s = abort_q | abort;

  // Break sequencer: next state, memory request setup and transfer bookkeeping.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    ma_d        = ma_q;
    out_d       = out_q;
    dir_d       = dir_q;
    fld_d       = fld_q;
    wcz_d       = wcz_q;
    abort_d     = (busy_q && abort) ? 1'b1 : abort_q;
    chan_push_s = 1'b0;
    chan_pop_s  = 1'b0;
    flush_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          dir_d   = dir_to_mem;
          fld_d   = field;
          ovf_d   = 1'b0;
          abort_d = 1'b0;
          flush_s = ~dir_to_mem;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (abort_seen_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else if (dir_q ? !fifo_empty_s : !fifo_full_s) begin
          rd_d    = 1'b1;
          ma_d    = {FLD0, WC_ADDR};
          state_d = S_WC_RD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WC_RD: begin
        if (mem_ack_s) begin
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          out_d   = ram_in + 12'd1;
          wcz_d   = (ram_in == 12'o7777);
          state_d = S_WC_WR;
        end else begin
          state_d = S_WC_RD;
        end
      end
      S_WC_WR: begin
        if (mem_ack_s) begin
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          ma_d    = {FLD0, CA_ADDR};
          state_d = S_CA_RD;
        end else begin
          state_d = S_WC_WR;
        end
      end
      S_CA_RD: begin
        if (mem_ack_s) begin
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          out_d   = ram_in + CA_STEP;
          state_d = S_CA_WR;
        end else begin
          state_d = S_CA_RD;
        end
      end
      S_CA_WR: begin
        // out_q still holds the new CA here; it becomes the data address within the latched field
        if (mem_ack_s) begin
          ma_d    = {fld_q, out_q};
          state_d = S_DAT;
          if (dir_q) begin
            wr_d       = 1'b1;
            out_d      = dev_rdata;
            chan_pop_s = 1'b1;
          end else begin
            wr_d = 1'b0;
            rd_d = 1'b1;
          end
        end else begin
          state_d = S_CA_WR;
        end
      end
      S_DAT: begin
        if (mem_ack_s) begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          chan_push_s = ~dir_q;
          if (wcz_q || abort_seen_s) begin
            ovf_d   = wcz_q ? 1'b1 : ovf_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_DAT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer/occupancy update; the channel takes priority over the device on a shared port.
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_data_s = dev_wdata;
    if (chan_push_s) begin
      push_s      = ~fifo_full_s;
      push_data_s = ram_in;
    end else begin
      push_s      = dev_wvalid & ~fifo_full_s;
      push_data_s = dev_wdata;
    end
    if (chan_pop_s) begin
      pop_s = ~fifo_empty_s;
    end else begin
      pop_s = dev_rready & ~fifo_empty_s;
    end
    if (flush_s) begin
      wptr_d = {FIFO_AW{1'b0}};
      rptr_d = {FIFO_AW{1'b0}};
      cnt_d  = {(FIFO_AW+1){1'b0}};
    end else begin
      wptr_d = wptr_q + FIFO_AW'(push_s);
      rptr_d = rptr_q + FIFO_AW'(pop_s);
      cnt_d  = cnt_q + (FIFO_AW+1)'(push_s) - (FIFO_AW+1)'(pop_s);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s && !flush_s) begin
      fifo_mem[wptr_q] <= push_data_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ma_q    <= {(FLD_W+12){1'b0}};
      out_q   <= 12'd0;
      dir_q   <= 1'b0;
      fld_q   <= FLD0;
      abort_q <= 1'b0;
      wcz_q   <= 1'b0;
      wptr_q  <= {FIFO_AW{1'b0}};
      rptr_q  <= {FIFO_AW{1'b0}};
      cnt_q   <= {(FIFO_AW+1){1'b0}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ma_q    <= ma_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      fld_q   <= fld_d;
      abort_q <= abort_d;
      wcz_q   <= wcz_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign wc_ovf        = ovf_q;
  assign ram_read_req  = rd_q;
  assign ram_write_req = wr_q;
  assign ram_ma        = ma_q;
  assign ram_out       = out_q;
  assign dev_wready    = ~fifo_full_s;
  assign dev_rvalid    = ~fifo_empty_s;
  assign dev_rdata     = fifo_mem[rptr_q];

endmodule
